// File: rtl/pci_addr_decoder.sv
// PCI slave address-phase decoder: FRAME# start detect, command latch, window decode, burst address tracking.
// Optional macro PARITY_CHK_EN adds par/serr address-phase even-parity checking.
module pci_addr_decoder #(
  parameter logic [31:0] BASE0     = 32'h1000_0000,
  parameter logic [31:0] BASE1     = 32'h2000_0000,
  parameter logic [31:0] BASE2     = 32'h3000_0000,
  parameter int          SIZE_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame,
  input  logic        irdy,
  input  logic        trdy,
  input  logic [31:0] ad,
  input  logic [3:0]  cbe,
`ifdef PARITY_CHK_EN
  input  logic        par,
  output logic        serr,
`endif
  output logic [1:0]  decoderOut,
  output logic [3:0]  cmd,
  output logic        cmdValid,
  output logic [31:0] curAddr
);

  typedef enum logic [1:0] {IDLE, DATA, MISS, TURN} stateT;

  stateT      state;
  logic       prevFrame;
  logic       startEdge;
  logic [1:0] hitWin;

  function automatic logic winMatch(input logic [31:0] a, input logic [31:0] base);
    return (a >> SIZE_BITS) == (base >> SIZE_BITS);
  endfunction

  function automatic logic [1:0] decodeWin(input logic [31:0] a, input logic [3:0] c);
    if (!((c == 4'b0110) || (c == 4'b0111))) decodeWin = 2'd3;
    else if (winMatch(a, BASE0))             decodeWin = 2'd0;
    else if (winMatch(a, BASE1))             decodeWin = 2'd1;
    else if (winMatch(a, BASE2))             decodeWin = 2'd2;
    else                                     decodeWin = 2'd3;
  endfunction

`ifdef PARITY_CHK_EN
  logic [31:0] adLatch;
  logic [3:0]  cbeLatch;
  logic        parPending;

  // Nonzero result means the AD/CBE/PAR set does not have even parity.
  function automatic logic parityErr(input logic [31:0] a, input logic [3:0] c, input logic p);
    return ^{a, c, p};
  endfunction
`endif

  // Live-bus start detect and window decode for the address-phase edge.
  always_comb begin
    startEdge = ~frame & prevFrame;
    hitWin    = decodeWin(ad, cbe);
  end

  // Transaction FSM with registered decode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prevFrame  <= 1'b0;
      decoderOut <= 2'd3;
      cmd        <= 4'd0;
      cmdValid   <= 1'b0;
      curAddr    <= 32'd0;
`ifdef PARITY_CHK_EN
      adLatch    <= 32'd0;
      cbeLatch   <= 4'd0;
      parPending <= 1'b0;
      serr       <= 1'b1;
`endif
    end else begin
      prevFrame <= frame;
`ifdef PARITY_CHK_EN
      serr       <= 1'b1;
      parPending <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (startEdge) begin
            curAddr <= ad;
            cmd     <= cbe;
`ifdef PARITY_CHK_EN
            adLatch    <= ad;
            cbeLatch   <= cbe;
            parPending <= 1'b1;
`endif
            if (hitWin != 2'd3) begin
              decoderOut <= hitWin;
              cmdValid   <= 1'b1;
              state      <= DATA;
            end else begin
              decoderOut <= 2'd3;
              cmdValid   <= 1'b0;
              state      <= MISS;
            end
          end else begin
            decoderOut <= 2'd3;
            cmdValid   <= 1'b0;
          end
        end
        DATA: begin
          if (!irdy && !trdy) begin
            curAddr <= curAddr + 32'd4;
            if (frame) begin
              decoderOut <= 2'd3;
              cmdValid   <= 1'b0;
              state      <= TURN;
            end
          end else if (frame && irdy) begin
            decoderOut <= 2'd3;
            cmdValid   <= 1'b0;
            state      <= IDLE;
          end
        end
        MISS: begin
          decoderOut <= 2'd3;
          cmdValid   <= 1'b0;
          if (frame && irdy) state <= IDLE;
        end
        TURN: begin
          decoderOut <= 2'd3;
          cmdValid   <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          decoderOut <= 2'd3;
          cmdValid   <= 1'b0;
          state      <= IDLE;
        end
      endcase
`ifdef PARITY_CHK_EN
      // A bad address parity overrides whatever the state logic chose on this edge.
      if (parPending && parityErr(adLatch, cbeLatch, par)) begin
        serr       <= 1'b0;
        decoderOut <= 2'd3;
        cmdValid   <= 1'b0;
        state      <= MISS;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pci_addr_decoder.sv
// Directed plus randomized bench for pci_addr_decoder; expectations come from window-range arithmetic.
module tb_pci_addr_decoder;

  localparam logic [31:0] BASE0     = 32'h1000_0000;
  localparam logic [31:0] BASE1     = 32'h2000_0000;
  localparam logic [31:0] BASE2     = 32'h3000_0000;
  localparam int          SIZE_BITS = 8;

  logic        clk = 1'b0;
  logic        rst_n, frame, irdy, trdy;
  logic [31:0] ad;
  logic [3:0]  cbe;
  logic [1:0]  decoderOut;
  logic [3:0]  cmd;
  logic        cmdValid;
  logic [31:0] curAddr;
`ifdef PARITY_CHK_EN
  logic        par, serr;
  logic        expSerr;
`endif

  int          nCmp = 0;
  int          nErr = 0;
  logic [31:0] expAddr;
  logic [1:0]  expDec;
  logic [3:0]  expCmd;
  logic        expValid;

  pci_addr_decoder dut (
    .clk(clk), .rst_n(rst_n), .frame(frame), .irdy(irdy), .trdy(trdy),
    .ad(ad), .cbe(cbe),
`ifdef PARITY_CHK_EN
    .par(par), .serr(serr),
`endif
    .decoderOut(decoderOut), .cmd(cmd), .cmdValid(cmdValid), .curAddr(curAddr)
  );

  always #5 clk = ~clk;

  // Reference decode: first window (lowest index) whose byte range contains the address.
  function automatic logic [1:0] refWin(input logic [31:0] a, input logic [3:0] c);
    logic [31:0] bases [3];
    bases  = '{BASE0, BASE1, BASE2};
    refWin = 2'd3;
    if (c == 4'b0110 || c == 4'b0111)
      for (int i = 2; i >= 0; i--)
        if (a >= bases[i] && (a - bases[i]) < (32'd1 << SIZE_BITS)) refWin = 2'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    chk({tag, ".decoderOut"}, 32'(decoderOut), 32'(expDec));
    chk({tag, ".cmdValid"},   32'(cmdValid),   32'(expValid));
    chk({tag, ".cmd"},        32'(cmd),        32'(expCmd));
    chk({tag, ".curAddr"},    curAddr,         expAddr);
`ifdef PARITY_CHK_EN
    chk({tag, ".serr"},       32'(serr),       32'(expSerr));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addrPhase(input logic [31:0] a, input logic [3:0] c, input string tag);
    frame = 1'b0; irdy = 1'b1; trdy = 1'b1; ad = a; cbe = c;
    tick();
    expAddr  = a;
    expCmd   = c;
    expDec   = refWin(a, c);
    expValid = (expDec != 2'd3);
    checkAll(tag);
    ad  = $urandom;
    cbe = 4'h0;
`ifdef PARITY_CHK_EN
    par = ^{a, c};
`endif
  endtask

  task automatic dataCycle(input logic xfer, input logic last, input string tag);
    frame = last; irdy = 1'b0; trdy = !xfer; ad = $urandom;
    tick();
    if (expValid) begin
      if (xfer) expAddr = expAddr + 32'd4;
      if (xfer && last) begin
        expDec   = 2'd3;
        expValid = 1'b0;
      end
    end
    checkAll(tag);
  endtask

  task automatic idleCycle(input string tag);
    frame = 1'b1; irdy = 1'b1; trdy = 1'b1;
    tick();
    expDec   = 2'd3;
    expValid = 1'b0;
    checkAll(tag);
  endtask

  initial begin
    rst_n = 1'b0; frame = 1'b1; irdy = 1'b1; trdy = 1'b1; ad = 32'd0; cbe = 4'd0;
    expAddr = 32'd0; expDec = 2'd3; expCmd = 4'd0; expValid = 1'b0;
`ifdef PARITY_CHK_EN
    par = 1'b0; expSerr = 1'b1;
`endif
    tick(); tick();
    checkAll("reset");
    rst_n = 1'b1;
    idleCycle("post_reset_idle");

    // Single-phase read on window 0.
    addrPhase(32'h1000_0010, 4'b0110, "w0_addr");
    dataCycle(1'b1, 1'b1, "w0_turn");
    idleCycle("w0_idle");

    // Burst on window 2 ending with TURN.
    addrPhase(32'h3000_00F8, 4'b0111, "w2_addr");
    dataCycle(1'b1, 1'b0, "w2_d0");
    dataCycle(1'b1, 1'b0, "w2_d1");
    dataCycle(1'b1, 1'b1, "w2_turn");
    idleCycle("w2_idle");

    // Miss by address; later falling FRAME# inside MISS is ignored.
    addrPhase(32'h4000_0000, 4'b0110, "miss_addr");
    dataCycle(1'b1, 1'b0, "miss_hold0");
    dataCycle(1'b0, 1'b1, "miss_hold1");
    frame = 1'b0; irdy = 1'b1; ad = BASE0; cbe = 4'b0110;
    tick();
    checkAll("miss_refall");
    idleCycle("miss_exit");

    // Miss by unsupported command (I/O read into window 0).
    addrPhase(32'h1000_0000, 4'b0010, "ioread_addr");
    dataCycle(1'b1, 1'b0, "ioread_hold");
    idleCycle("ioread_exit");

    // Window edges: last word inside, first word outside.
    addrPhase(BASE0 + 32'h0000_00FC, 4'b0111, "edge_in");
    dataCycle(1'b1, 1'b1, "edge_in_turn");
    idleCycle("edge_in_idle");
    addrPhase(BASE0 + 32'h0000_0100, 4'b0111, "edge_out");
    idleCycle("edge_out_idle");

    // Wait states on window 1, then master abort.
    addrPhase(BASE1 + 32'h0000_0020, 4'b0110, "wait_addr");
    repeat (4) dataCycle(1'b0, 1'b0, "wait_hold");
    dataCycle(1'b1, 1'b0, "wait_xfer");
    idleCycle("abort_idle");
    idleCycle("abort_idle2");

    // Asynchronous reset mid-burst with FRAME# held low.
    addrPhase(BASE0 + 32'h0000_0040, 4'b0110, "rst_addr");
    dataCycle(1'b1, 1'b0, "rst_d0");
    frame = 1'b0; irdy = 1'b0; trdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expDec = 2'd3; expValid = 1'b0; expAddr = 32'd0; expCmd = 4'd0;
    checkAll("rst_async");
    tick();
    rst_n = 1'b1; ad = BASE0; cbe = 4'b0110;
    repeat (3) begin
      tick();
      checkAll("rst_blocked");
    end
    idleCycle("rst_frame_high");
    addrPhase(BASE0, 4'b0110, "rst_redecode");
    dataCycle(1'b1, 1'b1, "rst_turn");
    idleCycle("rst_idle");

`ifdef PARITY_CHK_EN
    // Wrong address parity forces MISS with a one-cycle SERR# pulse.
    addrPhase(32'h2000_0000, 4'b0111, "par_addr");
    par = ~(^{32'h2000_0000, 4'b0111});
    frame = 1'b0; irdy = 1'b1; trdy = 1'b1;
    tick();
    expSerr = 1'b0; expDec = 2'd3; expValid = 1'b0;
    checkAll("par_err");
    tick();
    expSerr = 1'b1;
    checkAll("par_recover");
    idleCycle("par_idle");
`endif

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      logic [3:0]  c;
      logic [31:0] off;
      int          len;
      off = 32'($urandom_range(0, 63)) * 32'd4;
      case ($urandom_range(0, 3))
        0:       a = BASE0 + off;
        1:       a = BASE1 + off;
        2:       a = BASE2 + off;
        default: a = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) c = 4'($urandom);
      else c = ($urandom_range(0, 1) == 1) ? 4'b0111 : 4'b0110;
      addrPhase(a, c, "rnd_addr");
      if (expValid) begin
        len = $urandom_range(0, 5);
        for (int k = 0; k < len; k++) dataCycle($urandom_range(0, 1) == 1, 1'b0, "rnd_data");
        dataCycle(1'b1, 1'b1, "rnd_turn");
      end else begin
        dataCycle($urandom_range(0, 1) == 1, 1'b0, "rnd_miss");
      end
      idleCycle("rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/pci_addr_decoder.md
Name: pci_addr_decoder

Overview:
- Address-phase front end of the PCI slave. Sits directly upstream of the DEVSEL# generator.
- Detects the start of a transaction on FRAME# and latches AD and C/BE# during the address phase.
- Decodes the address against three base windows. Produces the 2-bit decoderOut code that the DEVSEL# stage consumes.
- Tracks the current burst address across data phases until the transaction ends.

Parameters:
- BASE0, 32'h1000_0000, base address of target window 0
- BASE1, 32'h2000_0000, base address of target window 1
- BASE2, 32'h3000_0000, base address of target window 2
- SIZE_BITS, 8, log2 of window size in bytes; compare uses ad[31:SIZE_BITS]

Ports:
- clk  in  1  PCI clock; all sampling on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame  in  1  FRAME#, active low
- irdy  in  1  IRDY#, active low
- trdy  in  1  TRDY#, active low; driven back from the slave data stage
- ad  in  32  multiplexed address/data bus
- cbe  in  4  C/BE# bus; carries the command in the address phase
- decoderOut  out  2  0/1/2 = hit on window 0/1/2; 3 = no hit or idle
- cmd  out  4  latched bus command
- cmdValid  out  1  high while a decoded transaction is active
- curAddr  out  32  address of the current data phase

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, decoderOut=3, cmd=0, cmdValid=0, curAddr=0.
  - prevFrame=0, so a start is only recognised after frame has been sampled high at least once post-reset.
- Start detect: prevFrame is frame registered each clk. The address phase is the edge where frame==0 and prevFrame==1.
- IDLE, on address phase:
  - Latch curAddr=ad and cmd=cbe.
  - Hit rule: command is memory read (4'b0110) or memory write (4'b0111), and ad[31:SIZE_BITS]==BASEi[31:SIZE_BITS].
  - On hit: decoderOut=i, cmdValid=1, go to DATA.
  - Otherwise (no hit, or unsupported command): decoderOut=3, cmdValid=0, go to MISS.
  - If more than one window matches, the lowest index wins.
- Timing: decoderOut is valid from the address-phase edge and held stable for the whole transaction. The DEVSEL# stage samples it on the next edge.
- DATA:
  - Each edge with irdy==0 && trdy==0 completes a data phase: curAddr += 4, wrapping modulo 2^32 with no window clamp.
  - If that completing edge also sees frame==1, it is the last data phase: go to TURN.
  - If frame==1 && irdy==1 (master abort or idle), go to IDLE immediately with decoderOut=3 and cmdValid=0.
  - Wait states (irdy or trdy high) hold all outputs.
- MISS: hold decoderOut=3. Go to IDLE when frame==1 && irdy==1.
- TURN: exactly one cycle; decoderOut=3, cmdValid=0; then IDLE. A new address phase is not accepted in TURN.
- A FRAME# falling edge while in DATA or MISS is ignored.
- Reset mid-transaction: return to IDLE at once. The remainder of that transaction is ignored, because prevFrame=0 blocks start detection until frame is seen high.
- Address arithmetic is unsigned 32-bit, and only the DATA state modifies curAddr.

Optional Feature:
- Macro: PARITY_CHK_EN
- Defined:
  - Adds input par (1 bit) and output serr (1 bit, active low, reset value 1).
  - On the edge after the address phase, par is checked for even parity over the latched ad, cbe and par.
  - On mismatch: serr=0 for exactly one cycle, decoderOut forced to 3, cmdValid=0, state goes to MISS.
  - The one-cycle decode latency is unchanged on a correct parity check.
- Undefined: no par or serr ports, and no parity checking.

Test Plan:
- Reset, then frame 1->0 with ad=32'h1000_0010, cbe=4'b0110 -> decoderOut=0 and cmdValid=1 on the address edge; curAddr=32'h1000_0010.
- Burst on window 2 at ad=32'h3000_00F8: three edges with irdy=0, trdy=0; frame=1 on the third -> curAddr goes F8, FC, 100, 104; one TURN cycle; decoderOut=3 one edge after TURN.
- ad=32'h4000_0000, or cbe=4'b0010 (I/O read) to 32'h1000_0000 -> decoderOut=3, cmdValid=0; MISS held until frame=1 and irdy=1, then IDLE.
- Wait states: irdy=0 with trdy=1 for 4 cycles in DATA -> curAddr and decoderOut unchanged.
- rst_n pulsed low mid-burst while frame stays 0 -> outputs return to reset values immediately; no new decode until frame goes 1 and then 0 again.
- With PARITY_CHK_EN, ad=32'h2000_0000, cbe=4'b0111, wrong par -> serr low for one cycle, decoderOut=3.
